// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO: issues registered reads, captures the
// returned word one cycle later and presents it on a valid/ready stream via a 2-entry buffer.
module fifo_stream_reader #(
    parameter int width = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_data_out,
    output logic             fifo_read,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] xfer_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             occ_q;
    occ_t             occ_d;
    logic [width-1:0] head_q;
    logic [width-1:0] head_d;
    logic [width-1:0] tail_q;
    logic [width-1:0] tail_d;
    logic             inflight_q;
    logic             inflight_d;
    logic             capture;
    logic             pop;
    logic             read_d;
    logic [1:0]       occ_cnt_d;
    logic [2:0]       pending_d;

    assign capture    = inflight_q;
    assign pop        = m_valid && m_ready;
    assign inflight_d = fifo_read && !fifo_empty;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            EMPTY: begin
                if (capture) begin
                    occ_d  = ONE;
                    head_d = fifo_data_out;
                end
            end
            ONE: begin
                // A pop and a capture in the same cycle replace the head with no bubble
                if (capture && pop) begin
                    head_d = fifo_data_out;
                end else if (capture) begin
                    occ_d  = TWO;
                    tail_d = fifo_data_out;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    occ_d  = ONE;
                    head_d = tail_q;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    // Only request a word if it is guaranteed a buffer slot when it returns two edges later
    always_comb begin
        occ_cnt_d = 2'd0;
        if (occ_d == TWO) begin
            occ_cnt_d = 2'd2;
        end else if (occ_d == ONE) begin
            occ_cnt_d = 2'd1;
        end
        pending_d = {1'b0, occ_cnt_d} + {2'b00, inflight_d};
        read_d    = enable && !fifo_empty && (pending_d < 3'd2);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            occ_q      <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            fifo_read  <= 1'b0;
            xfer_count <= '0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            fifo_read  <= read_d;
            if (pop) begin
                xfer_count <= xfer_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign m_valid = (occ_q != EMPTY);
    assign m_data  = head_q;
    assign busy    = (occ_q != EMPTY) || inflight_q || fifo_read;

    a_no_capture_when_full: assert property (
        @(posedge clk) disable iff (!rst_) !(inflight_q && (occ_q == TWO))
    );

endmodule
